// File: rtl/cpu_fetch_pkg.sv
// Shared definitions for the instruction-fetch reader: state encoding,
// default NOP word, instruction field positions and the alignment check.
package cpu_fetch_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_DRAIN = 2'd2,
      S_VALID = 2'd3
   } fetch_state_e;

   localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;

   // Field positions. The ISA numbers bits MSB-first (bit 0 = MSB), so
   // instr[0:5] is bits 31:26 in this little-endian vector.
   localparam int OPCODE_HI = 31;
   localparam int OPCODE_LO = 26;
   localparam int RS_HI     = 25;
   localparam int RS_LO     = 21;
   localparam int IMM16_HI  = 15;
   localparam int IMM16_LO  = 0;
   localparam int IMM26_HI  = 25;
   localparam int IMM26_LO  = 0;

   // The two LSBs (ISA bits 30:31) must be zero for a word fetch.
   localparam logic [31:0] ALIGN_MASK = 32'h0000_0003;

   function automatic logic is_aligned(input logic [31:0] addr);
      return (addr & ALIGN_MASK) == 32'h0;
   endfunction

endpackage

// File: rtl/fetch_timer.sv
// Saturating wait-cycle counter. Expires during the TIMEOUT_CYCLES-th
// enabled cycle after a clear; TIMEOUT_CYCLES = 0 disables expiry.
module fetch_timer #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] SAT  = CW'(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

   logic [CW-1:0] cnt;

   // Count enabled cycles from the last clear, holding at the saturation value.
   always_ff @(posedge clk) begin
      if (reset || clr)
         cnt <= '0;
      else if (en && cnt != SAT)
         cnt <= cnt + CW'(1);
   end

   assign expire = (TIMEOUT_CYCLES != 0) && en && (cnt >= LAST);

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch reader: req/ack handshake to instruction memory, holds
// the fetched word until the datapath retires it, stalls the PC meanwhile.
module instr_fetch
   import cpu_fetch_pkg::*;
#(
   parameter int          TIMEOUT_CYCLES = 16,
   parameter logic [31:0] NOP_WORD       = NOP_WORD_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc_addr,
   input  logic        fetch_en,
   input  logic        instr_taken,
   input  logic        flush,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic [5:0]  opcode,
   output logic [4:0]  rs,
   output logic [15:0] imm16,
   output logic [25:0] imm26,
   output logic        pc_stall,
   output logic        addr_fault,
   output logic        bus_fault
);

   fetch_state_e state, state_n;
   logic        req_n, af_n, bf_n;
   logic [31:0] addr_n, instr_n;
   logic        start, tmr_clr, tmr_en, tmr_exp;

   fetch_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
      .clk    (clk),
      .reset  (reset),
      .clr    (tmr_clr),
      .en     (tmr_en),
      .expire (tmr_exp)
   );

   // A new fetch starts from IDLE, or back-to-back when the held word retires.
   assign start = fetch_en &&
                  ((state == S_IDLE) || (state == S_VALID && !flush && instr_taken));

   // Next-state and next-register values; the handshake is never abandoned,
   // so a flush during WAIT drains the outstanding request instead.
   always_comb begin
      state_n = state;
      req_n   = mem_req;
      addr_n  = mem_addr;
      instr_n = instr;
      af_n    = addr_fault;
      bf_n    = bus_fault;
      case (state)
         S_WAIT: begin
            if (mem_ack) begin
               req_n   = 1'b0;
               state_n = flush ? S_IDLE : S_VALID;
               if (!flush) begin
                  instr_n = mem_rdata;
                  af_n    = 1'b0;
                  bf_n    = 1'b0;
               end
            end else if (flush) begin
               state_n = S_DRAIN;
            end else if (tmr_exp) begin
               req_n   = 1'b0;
               instr_n = NOP_WORD;
               af_n    = 1'b0;
               bf_n    = 1'b1;
               state_n = S_VALID;
            end
         end
         S_DRAIN: begin
            if (mem_ack || tmr_exp) begin
               req_n   = 1'b0;
               state_n = S_IDLE;
            end
         end
         S_VALID: begin
            if (flush || instr_taken)
               state_n = S_IDLE;
         end
         default: ;
      endcase
      // Start overrides the VALID->IDLE retire path above.
      if (start) begin
         if (is_aligned(pc_addr)) begin
            addr_n  = pc_addr;
            req_n   = 1'b1;
            state_n = S_WAIT;
         end else begin
            instr_n = NOP_WORD;
            af_n    = 1'b1;
            bf_n    = 1'b0;
            state_n = S_VALID;
         end
      end
   end

   // Timer runs while a request is outstanding, restarting on WAIT/DRAIN entry.
   assign tmr_en  = (state == S_WAIT) || (state == S_DRAIN);
   assign tmr_clr = ((state_n == S_WAIT) || (state_n == S_DRAIN)) && (state_n != state);

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         mem_req     <= 1'b0;
         mem_addr    <= 32'h0;
         instr       <= NOP_WORD;
         instr_valid <= 1'b0;
         addr_fault  <= 1'b0;
         bus_fault   <= 1'b0;
      end else begin
         state       <= state_n;
         mem_req     <= req_n;
         mem_addr    <= addr_n;
         instr       <= instr_n;
         instr_valid <= (state_n == S_VALID);
         addr_fault  <= af_n;
         bus_fault   <= bf_n;
      end
   end

   assign opcode = instr[OPCODE_HI:OPCODE_LO];
   assign rs     = instr[RS_HI:RS_LO];
   assign imm16  = instr[IMM16_HI:IMM16_LO];
   assign imm26  = instr[IMM26_HI:IMM26_LO];

   // PC may only advance on the cycle the held word is retired.
   assign pc_stall = ~(instr_valid & instr_taken);

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios with literal expectations, then
// random traffic checked every cycle against a transaction-level model.
module tb_instr_fetch;

   localparam int TO = 16;
   localparam logic [31:0] NOP = 32'h0;

   logic        clk = 1'b0;
   logic        reset, fetch_en, instr_taken, flush, mem_ack;
   logic [31:0] pc_addr, mem_rdata;
   logic        mem_req, instr_valid, pc_stall, addr_fault, bus_fault;
   logic [31:0] mem_addr, instr;
   logic [5:0]  opcode;
   logic [4:0]  rs;
   logic [15:0] imm16;
   logic [25:0] imm26;

   int vectors = 0;
   int miscompares = 0;

   // Reference model state: outstanding request, drain flag, held word.
   bit          m_known = 0;
   bit          m_req, m_drain, m_valid, m_af, m_bf;
   int          m_cnt;
   logic [31:0] m_addr, m_instr;

   always #5 clk = ~clk;

   instr_fetch #(.TIMEOUT_CYCLES(TO), .NOP_WORD(NOP)) dut (
      .clk(clk), .reset(reset), .pc_addr(pc_addr), .fetch_en(fetch_en),
      .instr_taken(instr_taken), .flush(flush), .mem_req(mem_req),
      .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .instr(instr), .instr_valid(instr_valid), .opcode(opcode), .rs(rs),
      .imm16(imm16), .imm26(imm26), .pc_stall(pc_stall),
      .addr_fault(addr_fault), .bus_fault(bus_fault)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic m_start(input logic [31:0] pa);
      if (pa % 4 == 0) begin
         m_req = 1; m_addr = pa; m_cnt = 0;
      end else begin
         m_valid = 1; m_instr = NOP; m_af = 1; m_bf = 0;
      end
   endtask

   // Advance the model by one clock using the inputs present at the edge.
   task automatic m_step();
      if (reset) begin
         m_known = 1; m_req = 0; m_drain = 0; m_valid = 0; m_af = 0; m_bf = 0;
         m_cnt = 0; m_addr = 0; m_instr = NOP;
      end else if (m_req) begin
         m_cnt++;
         if (mem_ack) begin
            m_req = 0;
            if (!m_drain && !flush) begin
               m_valid = 1; m_instr = mem_rdata; m_af = 0; m_bf = 0;
            end
            m_drain = 0;
         end else if (!m_drain && flush) begin
            m_drain = 1; m_cnt = 0;
         end else if (m_cnt >= TO) begin
            m_req = 0;
            if (!m_drain) begin
               m_valid = 1; m_instr = NOP; m_bf = 1; m_af = 0;
            end
            m_drain = 0;
         end
      end else if (m_valid) begin
         if (flush) m_valid = 0;
         else if (instr_taken) begin
            m_valid = 0;
            if (fetch_en) m_start(pc_addr);
         end
      end else if (fetch_en) begin
         m_start(pc_addr);
      end
   endtask

   task automatic compare_all();
      chk("mem_req",     32'(mem_req),     32'(m_req));
      chk("mem_addr",    mem_addr,         m_addr);
      chk("instr",       instr,            m_instr);
      chk("instr_valid", 32'(instr_valid), 32'(m_valid));
      chk("addr_fault",  32'(addr_fault),  32'(m_af));
      chk("bus_fault",   32'(bus_fault),   32'(m_bf));
      chk("opcode",      32'(opcode),      m_instr >> 26);
      chk("rs",          32'(rs),          (m_instr >> 21) % 32);
      chk("imm16",       32'(imm16),       m_instr % 65536);
      chk("imm26",       32'(imm26),       m_instr % (1 << 26));
      chk("pc_stall",    32'(pc_stall),    32'(!(m_valid && instr_taken)));
   endtask

   // One clock: apply inputs, check at the falling edge, step model at the
   // rising edge, return 1 time unit after it.
   task automatic cyc(input logic r, input logic fe, input logic [31:0] pa,
                      input logic tk, input logic fl, input logic ak,
                      input logic [31:0] rd);
      reset = r; fetch_en = fe; pc_addr = pa; instr_taken = tk;
      flush = fl; mem_ack = ak; mem_rdata = rd;
      @(negedge clk);
      if (m_known) compare_all();
      @(posedge clk);
      m_step();
      #1;
   endtask

   task automatic idle_cyc();
      cyc(0, 0, 32'h0, 0, 0, 0, 32'h0);
   endtask

   initial begin
      logic        r, fe, tk, fl, ak;
      logic [31:0] pa;

      // 1: basic fetch, 1-cycle ack.
      cyc(1, 0, 0, 0, 0, 0, 0);
      chk("rst_req", 32'(mem_req), 32'd0);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_addr", mem_addr, 32'h0);
      cyc(0, 1, 32'h40, 0, 0, 0, 0);
      chk("t1_req", 32'(mem_req), 32'd1);
      chk("t1_addr", mem_addr, 32'h40);
      chk("t1_valid_early", 32'(instr_valid), 32'd0);
      cyc(0, 0, 0, 0, 0, 1, 32'h8C22_0004);
      chk("t1_valid", 32'(instr_valid), 32'd1);
      chk("t1_opcode", 32'(opcode), 32'h23);
      chk("t1_rs", 32'(rs), 32'd1);
      chk("t1_imm16", 32'(imm16), 32'h4);
      chk("t1_imm26", 32'(imm26), 32'h0220004);
      cyc(0, 0, 0, 1, 0, 0, 0);
      chk("t1_retired", 32'(instr_valid), 32'd0);

      // 2: ack after 5 wait cycles.
      cyc(0, 1, 32'h100, 0, 0, 0, 0);
      repeat (5) idle_cyc();
      chk("t2_req_held", 32'(mem_req), 32'd1);
      chk("t2_addr_held", mem_addr, 32'h100);
      chk("t2_not_valid", 32'(instr_valid), 32'd0);
      cyc(0, 0, 0, 0, 0, 1, 32'h1234_5678);
      chk("t2_instr", instr, 32'h1234_5678);
      cyc(0, 0, 0, 1, 0, 0, 0);

      // 3: misaligned address.
      cyc(0, 1, 32'h42, 0, 0, 0, 0);
      chk("t3_req", 32'(mem_req), 32'd0);
      chk("t3_af", 32'(addr_fault), 32'd1);
      chk("t3_valid", 32'(instr_valid), 32'd1);
      chk("t3_instr", instr, 32'h0);
      cyc(0, 0, 0, 1, 0, 0, 0);

      // 4: timeout.
      cyc(0, 1, 32'h200, 0, 0, 0, 0);
      repeat (15) idle_cyc();
      chk("t4_req_15", 32'(mem_req), 32'd1);
      idle_cyc();
      chk("t4_req_16", 32'(mem_req), 32'd0);
      chk("t4_bf", 32'(bus_fault), 32'd1);
      chk("t4_valid", 32'(instr_valid), 32'd1);
      chk("t4_instr", instr, 32'h0);
      cyc(0, 0, 0, 1, 0, 0, 0);

      // 5: flush mid-wait, late ack discarded.
      cyc(0, 1, 32'h300, 0, 0, 0, 0);
      idle_cyc();
      cyc(0, 0, 0, 0, 1, 0, 0);
      idle_cyc();
      chk("t5_req_drain", 32'(mem_req), 32'd1);
      cyc(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFF);
      chk("t5_req_done", 32'(mem_req), 32'd0);
      chk("t5_valid", 32'(instr_valid), 32'd0);
      idle_cyc();
      chk("t5_valid_after", 32'(instr_valid), 32'd0);

      // 6: back-to-back fetches, then reset mid-wait with a late ack.
      cyc(0, 1, 32'h0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 1, 32'hA0A0_0001);
      chk("t6_w0", instr, 32'hA0A0_0001);
      cyc(0, 1, 32'h4, 1, 0, 0, 0);
      chk("t6_addr1", mem_addr, 32'h4);
      chk("t6_gap", 32'(instr_valid), 32'd0);
      cyc(0, 0, 0, 0, 0, 1, 32'hB0B0_0002);
      chk("t6_w1", instr, 32'hB0B0_0002);
      cyc(0, 1, 32'h8, 1, 0, 0, 0);
      chk("t6_addr2", mem_addr, 32'h8);
      cyc(0, 0, 0, 0, 0, 1, 32'hC0C0_0003);
      chk("t6_w2", instr, 32'hC0C0_0003);
      cyc(0, 1, 32'hC, 1, 0, 0, 0);
      chk("t6_req3", 32'(mem_req), 32'd1);
      cyc(1, 0, 0, 0, 0, 0, 0);
      chk("t6_rst_req", 32'(mem_req), 32'd0);
      cyc(0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
      chk("t6_late_ack_req", 32'(mem_req), 32'd0);
      chk("t6_late_ack_valid", 32'(instr_valid), 32'd0);

      // Random traffic.
      for (int i = 0; i < 4000; i++) begin
         r  = ($urandom_range(0, 299) == 0);
         fe = $urandom_range(0, 1);
         tk = $urandom_range(0, 1);
         fl = ($urandom_range(0, 9) == 0);
         pa = {$urandom() % (1 << 30), 2'b00};
         if ($urandom_range(0, 7) == 0) pa[1:0] = 2'($urandom_range(1, 3));
         ak = m_req ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
         cyc(r, fe, pa, tk, fl, ak, $urandom());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
